gray_updown_counter: RTL and testbench

Parametrised up/down counter that keeps its state in binary and presents both binary and Gray-coded outputs, registered and mutually consistent every cycle. It generalises the combinational binary-to-Gray converter, adding WIDTH and reset-value parameters, count direction, and a parallel load in either binary or Gray encoding. It also raises a wrap pulse. It is intended for pointer generation (e.g. FIFO read/write pointers crossing clock domains) and for position/sequence counters.

---
 rtl/gray_pkg.sv | 21 ++
 rtl/gray_updown_counter.sv | 74 +++++++
 tb/tb_gray_updown_counter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Binary/Gray conversion helpers shared by the Gray-coded counter.
// Functions work at GRAY_MAX_W bits; callers zero-extend narrower values and truncate results.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] b2g(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits leave the prefix XOR unchanged, so no width argument is needed.
    function automatic logic [GRAY_MAX_W-1:0] g2b(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_updown_counter.sv
// Up/down counter holding binary state with a separately registered Gray copy,
// parallel load in either encoding, a registered wrap pulse and a combinational terminal count.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap,
    output logic             tc
);

    localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(b2g(GRAY_MAX_W'(RESET_VAL)));
    localparam logic [WIDTH-1:0] ALL_ONES   = '1;
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    // NOTE: every variable gets a default before the if-chain so no path leaves it unassigned (no latch).
    always_comb begin
        bin_d  = bin_q;
        gray_d = gray_q;
        wrap_d = 1'b0;
        if (load) begin
            if (load_gray) begin
                bin_d  = WIDTH'(g2b(GRAY_MAX_W'(load_val)));
                gray_d = load_val;
            end else begin
                bin_d  = load_val;
                gray_d = WIDTH'(b2g(GRAY_MAX_W'(load_val)));
            end
        end else if (en) begin
            if (up) begin
                bin_d  = bin_q + ONE;
                wrap_d = (bin_q == ALL_ONES);
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = (bin_q == '0);
            end
            // Gray is encoded from the next binary value so it lands in its own flop, glitch-free.
            gray_d = WIDTH'(b2g(GRAY_MAX_W'(bin_d)));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= RESET_VAL;
            gray_q <= RESET_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;
    assign tc   = up ? (bin_q == ALL_ONES) : (bin_q == '0);

endmodule

// File: tb/tb_gray_updown_counter.sv
// Self-checking bench for gray_updown_counter (WIDTH=8, RESET_VAL=0): directed vectors with
// literal expectations plus an arithmetic model compared on every falling clock edge.
module tb_gray_updown_counter;

    localparam int W   = 8;
    localparam int MOD = 256;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en, up, load, load_gray;
    logic [W-1:0] load_val;
    logic [W-1:0] dut_bin, dut_gray;
    logic         dut_wrap, dut_tc;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: plain integers, modulo arithmetic.
    int m_bin  = 0;
    int m_wrap = 0;
    int m_step = 0;
    bit cmp_on = 1'b0;
    logic [W-1:0] prev_gray = '0;

    gray_updown_counter #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_gray (load_gray),
        .load_val  (load_val),
        .bin       (dut_bin),
        .gray      (dut_gray),
        .wrap      (dut_wrap),
        .tc        (dut_tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    // Decode a Gray code by searching for the binary value whose encoding matches.
    function automatic int bin_of_gray(input int g);
        for (int b = 0; b < MOD; b++) begin
            if (gray_of(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_bin  = 0;
        m_wrap = 0;
        m_step = 0;
    endtask

    // Drive one cycle's inputs, let the edge happen, then advance the model.
    task automatic tick(input bit e, input bit u, input bit ld, input bit lg, input int lv);
        en        = e;
        up        = u;
        load      = ld;
        load_gray = lg;
        load_val  = W'(lv);
        @(posedge clk);
        if (ld) begin
            m_bin  = lg ? bin_of_gray(lv) : lv;
            m_wrap = 0;
            m_step = 0;
        end else if (e) begin
            if (u) begin
                m_wrap = (m_bin == MOD - 1);
                m_bin  = (m_bin + 1) % MOD;
            end else begin
                m_wrap = (m_bin == 0);
                m_bin  = (m_bin + MOD - 1) % MOD;
            end
            m_step = 1;
        end else begin
            m_wrap = 0;
            m_step = 0;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_bin",  dut_bin,  m_bin);
            check("model_gray", dut_gray, gray_of(m_bin));
            check("model_wrap", dut_wrap, m_wrap);
            check("model_tc",   dut_tc,   up ? (m_bin == MOD - 1) : (m_bin == 0));
            if (m_step != 0) begin
                check("gray_one_bit_step", $countones(dut_gray ^ prev_gray), 1);
            end
            prev_gray = dut_gray;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_gray = 1'b0; load_val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cmp_on = 1'b1;
        check("reset_bin",  dut_bin,  8'h00);
        check("reset_gray", dut_gray, 8'h00);
        check("reset_wrap", dut_wrap, 1'b0);
        check("reset_tc",   dut_tc,   1'b0);

        tick(1, 1, 0, 0, 0); check("up1_bin", dut_bin, 8'h01); check("up1_gray", dut_gray, 8'h01);
        tick(1, 1, 0, 0, 0); check("up2_bin", dut_bin, 8'h02); check("up2_gray", dut_gray, 8'h03);
        tick(1, 1, 0, 0, 0); check("up3_bin", dut_bin, 8'h03); check("up3_gray", dut_gray, 8'h02);
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0); check("pre_rst_bin", dut_bin, 8'h05);

        // Asynchronous reset between edges must clear state without a clock edge.
        rst_n = 1'b0;
        model_reset();
        #2;
        check("async_rst_bin",  dut_bin,  8'h00);
        check("async_rst_gray", dut_gray, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        tick(0, 1, 1, 0, 8'h51); check("ld_bin_bin",  dut_bin, 8'h51); check("ld_bin_gray",  dut_gray, 8'h79);
        tick(0, 1, 1, 1, 8'h79); check("ld_gray_bin", dut_bin, 8'h51); check("ld_gray_gray", dut_gray, 8'h79);

        tick(0, 1, 1, 0, 8'hFF); check("ff_gray", dut_gray, 8'h80); check("ff_tc", dut_tc, 1'b1);
        tick(1, 1, 0, 0, 0);
        check("wrap_up_bin", dut_bin, 8'h00); check("wrap_up_gray", dut_gray, 8'h00); check("wrap_up_wrap", dut_wrap, 1'b1);
        tick(1, 1, 0, 0, 0); check("after_wrap_bin", dut_bin, 8'h01); check("after_wrap_wrap", dut_wrap, 1'b0);

        tick(0, 0, 1, 0, 8'h00); check("zero_tc_down", dut_tc, 1'b1);
        tick(1, 0, 0, 0, 0);
        check("wrap_dn_bin", dut_bin, 8'hFF); check("wrap_dn_gray", dut_gray, 8'h80); check("wrap_dn_wrap", dut_wrap, 1'b1);
        tick(1, 0, 0, 0, 0);
        check("dn_bin", dut_bin, 8'hFE); check("dn_gray", dut_gray, 8'h81); check("dn_wrap", dut_wrap, 1'b0);

        // Reversing at a terminal value is an ordinary step, not a wrap.
        tick(0, 1, 1, 0, 8'hFF);
        tick(1, 0, 0, 0, 0); check("rev_bin", dut_bin, 8'hFE); check("rev_wrap", dut_wrap, 1'b0);

        tick(0, 1, 1, 0, 8'hFF);
        tick(1, 1, 1, 0, 8'h10);
        check("ld_wins_bin", dut_bin, 8'h10); check("ld_wins_gray", dut_gray, 8'h18); check("ld_wins_wrap", dut_wrap, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(0, i[0], 0, 0, 0);
            check("hold_bin", dut_bin, 8'h10); check("hold_wrap", dut_wrap, 1'b0);
        end

        // Full sweep up through a wrap, then mixed-direction steps and loads checked by the model.
        for (int i = 0; i < 260; i++) tick(1, 1, 0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            tick(($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 15) == 0),
                 $urandom_range(0, 1), $urandom_range(0, 255));
        end

        @(negedge clk);
        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
